fetch_ctrl: RTL and testbench

Sequencing controller for the instruction-fetch stage. Each cycle it drives the fetch stage's hold, redirect-select and redirect-address inputs from four sources: branch resolution, pipeline stall requests, instruction-memory readiness and the HLT instruction. A redirect that collides with a stall is held until it can be applied, so the fetch stage never loses one. The block sits between the hazard/branch logic and the PC register, and keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/fetch_ctrl_pkg.sv | 15 +
 rtl/sat_counter.sv | 18 +
 rtl/fetch_ctrl.sv | 118 +++++++++++
 tb/tb_fetch_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencing controller.
package fetch_ctrl_pkg;

  localparam int ADDR_W = 16;

  // Opcode decode compares against to raise halt_instr.
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; reusable for perf counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr)
      count <= '0;
    else if (inc && (count != {W{1'b1}}))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencing: drives hold/redirect from branch, stall, imem and HLT,
// parking a blocked redirect until it can be applied.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 16'h0000,
  parameter int                CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_req,
  input  logic              imem_ready,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              halt_instr,
  input  logic              resume,
  input  logic [ADDR_W-1:0] resume_addr,
  output logic              hlt,
  output logic              use_alt,
  output logic [ADDR_W-1:0] alt_address,
  output logic              squash,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_t            state;
  logic              pend_v;
  logic [ADDR_W-1:0] pend_a;
  logic              squash_q;
  logic              blocked;
  logic              redir;
  logic              go_halt;

  assign blocked = stall_req | ~imem_ready;
  assign redir   = br_taken | pend_v;

  always_comb begin
    hlt         = 1'b1;
    use_alt     = 1'b0;
    alt_address = '0;
    go_halt     = 1'b0;
    if (!rst) begin
      case (state)
        ST_BOOT: begin
          hlt         = 1'b0;
          use_alt     = 1'b1;
          alt_address = RESET_VECTOR;
        end
        ST_RUN: begin
          // A fresh branch overrides any parked redirect.
          if (redir) begin
            if (!blocked) begin
              hlt         = 1'b0;
              use_alt     = 1'b1;
              alt_address = br_taken ? br_target : pend_a;
            end
          end else if (halt_instr && !squash_q) begin
            go_halt = 1'b1;
          end else if (!blocked) begin
            hlt = 1'b0;
          end
        end
        ST_HALTED: begin
          if (resume) begin
            hlt         = 1'b0;
            use_alt     = 1'b1;
            alt_address = resume_addr;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_BOOT;
      pend_v   <= 1'b0;
      pend_a   <= '0;
      squash_q <= 1'b0;
    end else begin
      squash_q <= use_alt & ~hlt;
      case (state)
        ST_BOOT: state <= ST_RUN;
        ST_RUN: begin
          if (redir) begin
            if (!blocked) begin
              pend_v <= 1'b0;
            end else if (br_taken) begin
              pend_v <= 1'b1;
              pend_a <= br_target;
            end
          end else if (go_halt) begin
            state  <= ST_HALTED;
            pend_v <= 1'b0;
          end
        end
        ST_HALTED: begin
          pend_v <= 1'b0;
          if (resume) state <= ST_RUN;
        end
        default: state <= ST_BOOT;
      endcase
    end
  end

  // Outputs read as idle during the reset cycle even before the first reset edge lands.
  assign squash = squash_q & ~rst;
  assign halted = (state == ST_HALTED) & ~rst;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   ((state == ST_RUN) & hlt & ~rst),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Vector-table bench for fetch_ctrl (CNT_W=4 build so saturation is reachable).
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_req;
  logic        imem_ready;
  logic        br_taken;
  logic [15:0] br_target;
  logic        halt_instr;
  logic        resume;
  logic [15:0] resume_addr;
  logic        hlt;
  logic        use_alt;
  logic [15:0] alt_address;
  logic        squash;
  logic        halted;
  logic [3:0]  stall_cnt;

  int checks   = 0;
  int failures = 0;

  fetch_ctrl #(.RESET_VECTOR(16'h0000), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_req   (stall_req),
    .imem_ready  (imem_ready),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .halt_instr  (halt_instr),
    .resume      (resume),
    .resume_addr (resume_addr),
    .hlt         (hlt),
    .use_alt     (use_alt),
    .alt_address (alt_address),
    .squash      (squash),
    .halted      (halted),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, st, rdy, bt;
    logic [15:0] tgt;
    logic        hi, res;
    logic [15:0] raddr;
    logic        e_hlt, e_ua;
    logic [15:0] e_alt;
    logic        e_sq, e_hd;
    logic [3:0]  e_cnt;
    logic        chk_cnt;
  } vec_t;

  typedef struct {
    int          row;
    logic        hlt, ua;
    logic [15:0] alt;
    logic        sq, hd;
    logic [3:0]  cnt;
    logic        chk_cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(logic r, logic st, logic rdy, logic bt, logic [15:0] tgt,
                              logic hi, logic res, logic [15:0] raddr,
                              logic e_hlt, logic e_ua, logic [15:0] e_alt,
                              logic e_sq, logic e_hd, logic [3:0] e_cnt, logic cc);
    vec_t v;
    v.rst = r; v.st = st; v.rdy = rdy; v.bt = bt; v.tgt = tgt;
    v.hi = hi; v.res = res; v.raddr = raddr;
    v.e_hlt = e_hlt; v.e_ua = e_ua; v.e_alt = e_alt;
    v.e_sq = e_sq; v.e_hd = e_hd; v.e_cnt = e_cnt; v.chk_cnt = cc;
    return v;
  endfunction

  task automatic chk(int row, string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL row%0d %s got=%h expected=%h", row, name, act, exp);
    end
  endtask

  task automatic apply(int row, vec_t v);
    exp_t e;
    rst = v.rst; stall_req = v.st; imem_ready = v.rdy; br_taken = v.bt;
    br_target = v.tgt; halt_instr = v.hi; resume = v.res; resume_addr = v.raddr;
    e.row = row; e.hlt = v.e_hlt; e.ua = v.e_ua; e.alt = v.e_alt;
    e.sq = v.e_sq; e.hd = v.e_hd; e.cnt = v.e_cnt; e.chk_cnt = v.chk_cnt;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk(e.row, "hlt", {15'd0, hlt}, {15'd0, e.hlt});
    chk(e.row, "use_alt", {15'd0, use_alt}, {15'd0, e.ua});
    chk(e.row, "alt_address", alt_address, e.alt);
    chk(e.row, "squash", {15'd0, squash}, {15'd0, e.sq});
    chk(e.row, "halted", {15'd0, halted}, {15'd0, e.hd});
    if (e.chk_cnt) chk(e.row, "stall_cnt", {12'd0, stall_cnt}, {12'd0, e.cnt});
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            rst st rdy bt tgt      hi res raddr    hlt ua alt      sq hd cnt cc
    vecs.push_back(mk(1, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0000, 0, 0, 0, 1)); // BOOT
    vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 16'h0040, 0, 0, 16'h0000, 0, 1, 16'h0040, 0, 0, 0, 1)); // branch
    vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 1, 16'h0100, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 0, 1)); // blocked br
    vecs.push_back(mk(0, 1, 1, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 1, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 2, 1));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0100, 0, 0, 3, 1));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 3, 1));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 3, 1));
    vecs.push_back(mk(0, 0, 0, 1, 16'h0100, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 3, 1)); // override
    vecs.push_back(mk(0, 0, 0, 1, 16'h0200, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 4, 1));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0200, 0, 0, 5, 1));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 5, 1));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 5, 1));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 1, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 5, 1)); // HLT
    vecs.push_back(mk(0, 0, 1, 1, 16'h0300, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 1, 6, 1));
    vecs.push_back(mk(0, 1, 1, 0, 16'h0000, 0, 1, 16'h0010, 0, 1, 16'h0010, 0, 1, 6, 1)); // resume
    vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 6, 1));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 6, 1));
    for (int i = 0; i < 11; i++) begin
      logic [3:0] c;
      c = (6 + i > 15) ? 4'hF : 4'(6 + i);
      vecs.push_back(mk(0, 1, 1, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, c, 1));
    end
    vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 15, 1));
    vecs.push_back(mk(0, 1, 1, 1, 16'h0500, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 15, 1)); // parked
    vecs.push_back(mk(1, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0000, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 1));

    rst = 1'b1; stall_req = 1'b0; imem_ready = 1'b1; br_taken = 1'b0;
    br_target = '0; halt_instr = 1'b0; resume = 1'b0; resume_addr = '0;
    @(posedge clk);
    #1;
    foreach (vecs[i]) apply(i, vecs[i]);

    // Reset while HALTED must drop halted and restart from the boot vector.
    apply(100, mk(0, 0, 1, 0, 16'h0000, 1, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 0, 1));
    apply(101, mk(0, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 1, 1, 1));
    apply(102, mk(1, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 0, 0));
    apply(103, mk(0, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0000, 0, 0, 0, 1));
    apply(104, mk(0, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
